pcm_deserializer: RTL and testbench
===================================

Name: pcm_deserializer

Overview:
- I2S receiver; the receive-side counterpart of the team's PCM serializer. Takes a 3-wire I2S stream (bit clock, LR select, serial data) from an external ADC or codec and recovers stereo 16-bit PCM words.
- The I2S inputs are oversampled in the system clock domain; no logic is clocked by the bit clock.
- Delivers each left/right pair to the tracker mixer/recorder logic with a one-cycle valid strobe and a framing-error flag.

Parameters:
- DATA_WIDTH, 16, bits per channel slot (MSB first, I2S one-bit delay).
- SYNC_STAGES, 2, flops in each input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the I2S bit-clock rate.
- rst_active_low  input  1  asynchronous, active-low reset.
- bit_clock_in  input  1  I2S bit clock, asynchronous to clk.
- LR_select_in  input  1  I2S word select (0=Left, 1=Right), changes on the bit-clock falling edge.
- serial_data_in  input  1  I2S serial data.
- pcm_data_left  output  DATA_WIDTH  last complete left word.
- pcm_data_right  output  DATA_WIDTH  last complete right word.
- pcm_data_valid  output  1  one-clk pulse when a new stereo pair is presented.
- frame_error  output  1  one-clk pulse when a slot length is wrong.

Behaviour:
- Reset (async assert, sync release):
  - pcm_data_left=0, pcm_data_right=0, pcm_data_valid=0, frame_error=0.
  - Shift register, bit counter and left-hold register cleared; FSM enters SEEK.
  - Reset asserted mid-frame aborts all state; the partial word is never output.
- Input path:
  - Each of the three inputs passes through SYNC_STAGES flops.
  - A bit-clock rising edge ("rise") is a cycle where the synchronized bit clock is 1 and its previous value was 0.
  - All sampling happens only in rise cycles, using the synchronized data and LR values from the same stage.
- FSM states: SEEK, LEFT, RIGHT.
- SEEK:
  - Ignore data until a rise where LR differs from the LR sampled at the previous rise.
  - On that rise: clear the bit counter, then go to LEFT if the new LR=0, or RIGHT if it is 1.
  - The bit on that rise is discarded.
- LEFT/RIGHT, rise with LR unchanged:
  - Shift data into the LSB of the shift register.
  - bit_cnt increments, saturating at DATA_WIDTH.
- LEFT/RIGHT, rise with LR changed (I2S LSB-after-transition bit):
  - Shift the bit in as the final LSB.
  - If bit_cnt == DATA_WIDTH-1, the word is complete. Otherwise pulse frame_error, discard the word and clear left-hold valid.
  - Complete word in LEFT: store it in the left-hold register and set left-hold valid.
  - Complete word in RIGHT with left-hold valid: load pcm_data_left from left-hold and pcm_data_right from the new word, pulse pcm_data_valid, clear left-hold valid.
  - Complete word in RIGHT without left-hold valid: drop it, with no valid pulse and no error.
  - In every case clear bit_cnt and move to the state matching the new LR.
- Latency: outputs and the valid pulse are registered. They become visible on the clk edge immediately after the rise cycle of the final bit, i.e. the cycle after the rise cycle is detected.
- Output stability: pcm_data_left and pcm_data_right are written only together with pcm_data_valid and hold otherwise. frame_error never alters them.
- frame_error and pcm_data_valid are never asserted in the same cycle.
- Slot longer than DATA_WIDTH: bit_cnt saturates, so the word is rejected with frame_error at the transition.
- Bit-clock glitches shorter than SYNC_STAGES clk cycles are out of scope; the clk ratio requirement is the documented precondition.

Decomposition:
- Package tracker_audio_pkg:
  - PCM_WIDTH=16.
  - Typedef pcm_sample_t (logic [PCM_WIDTH-1:0]).
  - Enum i2s_rx_state_t {SEEK, LEFT, RIGHT}.
  - Constants CH_LEFT=0, CH_RIGHT=1.
  - The serializer shares this package.
- Sub-module sync_edge_detect: parameterised SYNC_STAGES synchronizer plus rising-edge detector, async active-low reset. It is instantiated for the bit clock, and its synchronizer alone is reused for LR and data.

Test Plan:
- Reset, then two full frames, left=0xA5C3 and right=0x1234, at clk = 16x bit clock -> first frame dropped (SEEK/partial); second frame gives one pcm_data_valid pulse with left=0xA5C3, right=0x1234 and frame_error=0 throughout.
- Back-to-back frames (0x8000,0x7FFF) then (0xFFFF,0x0001) -> two valid pulses exactly 32 bit clocks apart. Outputs hold between pulses, and extreme values are received bit-exact.
- Left slot of 15 bits, then a correct right slot -> frame_error pulse at the LR transition; no pcm_data_valid for that frame; outputs keep prior values.
- Right slot of 17 bits -> frame_error pulse; next correct frame (0x0F0F,0xF0F0) -> valid with those values.
- Assert rst_active_low=0 for 3 clks in the middle of a right slot -> all outputs 0 immediately (async). No valid until a complete left+right pair after the next LR transition.
- Bit-clock phase randomly offset to clk, ratio 8x -> 100 random frames received with zero errors and values matching the sent words.

Source files
------------

// File: rtl/tracker_audio_pkg.sv
// Shared definitions for the tracker audio path (I2S serializer and deserializer).
package tracker_audio_pkg;
  localparam int PCM_WIDTH = 16;

  typedef logic [PCM_WIDTH-1:0] pcm_sample_t;

  typedef enum logic [1:0] {
    SEEK,
    LEFT,
    RIGHT
  } i2s_rx_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an edge input plus companion data bits, with a
// rising-edge strobe on the edge input aligned to the synchronized data.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edge_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             rise,
  output logic [WIDTH-1:0] data_sync
);
  // Bit 0 of each stage carries the edge input; data rides in the same stage
  // so sampled data is never skewed against the detected edge.
  logic [SYNC_STAGES-1:0][WIDTH:0] sync_q, sync_d;
  logic                            prev_q, prev_d;

  always_comb begin
    sync_d[0] = {data_in, edge_in};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_q[SYNC_STAGES-1][0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1][0] & ~prev_q;
  assign data_sync = sync_q[SYNC_STAGES-1][WIDTH:1];
endmodule

// File: rtl/pcm_deserializer.sv
// I2S receiver: oversamples BCLK/LRCK/SDATA in the clk domain and delivers
// stereo PCM pairs with a one-cycle valid strobe and a framing-error strobe.
module pcm_deserializer
  import tracker_audio_pkg::*;
#(
  parameter int DATA_WIDTH  = PCM_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_active_low,
  input  logic                  bit_clock_in,
  input  logic                  LR_select_in,
  input  logic                  serial_data_in,
  output logic [DATA_WIDTH-1:0] pcm_data_left,
  output logic [DATA_WIDTH-1:0] pcm_data_right,
  output logic                  pcm_data_valid,
  output logic                  frame_error
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic                  rise, lr_s, data_s, lr_chg;
  logic [1:0]            sync_data;
  i2s_rx_state_t         state_q;
  logic [DATA_WIDTH-2:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] left_hold_q, left_q, right_q, word;
  logic                  left_vld_q, lr_prev_q, valid_q, err_q, word_ok;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(2)) u_sync (
    .clk       (clk),
    .rst_n     (rst_active_low),
    .edge_in   (bit_clock_in),
    .data_in   ({serial_data_in, LR_select_in}),
    .rise      (rise),
    .data_sync (sync_data)
  );

  assign {data_s, lr_s} = sync_data;
  assign lr_chg  = lr_s != lr_prev_q;
  // The bit on the LR transition is the LSB of the slot just ending.
  assign word    = {shift_q, data_s};
  assign word_ok = bit_cnt_q == CNT_W'(DATA_WIDTH - 1);

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      state_q     <= SEEK;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      left_hold_q <= '0;
      left_vld_q  <= 1'b0;
      lr_prev_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (rise) begin
        lr_prev_q <= lr_s;
        case (state_q)
          SEEK: begin
            if (lr_chg) begin
              bit_cnt_q <= '0;
              state_q   <= (lr_s == CH_LEFT) ? LEFT : RIGHT;
            end
          end
          LEFT, RIGHT: begin
            if (!lr_chg) begin
              shift_q <= {shift_q[DATA_WIDTH-3:0], data_s};
              if (bit_cnt_q != CNT_W'(DATA_WIDTH)) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else begin
              if (!word_ok) begin
                err_q      <= 1'b1;
                left_vld_q <= 1'b0;
              end else if (state_q == LEFT) begin
                left_hold_q <= word;
                left_vld_q  <= 1'b1;
              end else if (left_vld_q) begin
                // A right word without a preceding left is dropped silently.
                left_q     <= left_hold_q;
                right_q    <= word;
                valid_q    <= 1'b1;
                left_vld_q <= 1'b0;
              end
              bit_cnt_q <= '0;
              state_q   <= (lr_s == CH_LEFT) ? LEFT : RIGHT;
            end
          end
          default: state_q <= SEEK;
        endcase
      end
    end
  end

  assign pcm_data_left  = left_q;
  assign pcm_data_right = right_q;
  assign pcm_data_valid = valid_q;
  assign frame_error    = err_q;
endmodule

// File: tb/tb_pcm_deserializer.sv
// Directed I2S stream into pcm_deserializer; expected pairs/errors are queued
// by the stimulus and popped by an independent output monitor.
`timescale 1ns/1ps
module tb_pcm_deserializer;
  logic        clk = 1'b0, rst_n = 1'b0, bclk = 1'b0, lr = 1'b0, sdata = 1'b0;
  logic [15:0] left, right;
  logic        valid, ferr;

  pcm_deserializer dut (
    .clk            (clk),
    .rst_active_low (rst_n),
    .bit_clock_in   (bclk),
    .LR_select_in   (lr),
    .serial_data_in (sdata),
    .pcm_data_left  (left),
    .pcm_data_right (right),
    .pcm_data_valid (valid),
    .frame_error    (ferr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [15:0] l;
    logic [15:0] r;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned valid_cyc[$];
  int          checks = 0, fails = 0;
  int unsigned cyc = 0;
  logic [15:0] hold_l = '0, hold_r = '0;
  int          half_ns = 80;
  logic        carry = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected event per strobe; between strobes outputs must hold.
  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (!rst_n) begin
      hold_l = '0;
      hold_r = '0;
    end else begin
      if (valid || ferr) begin
        chk("valid_err_exclusive", 32'(valid & ferr), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_event: valid=%b err=%b l=%h r=%h, nothing expected", valid, ferr, left, right);
        end else begin
          e = exp_q.pop_front();
          chk("event_is_err", 32'(ferr), 32'(e.is_err));
          if (valid && !e.is_err) begin
            chk("pcm_left", 32'(left), 32'(e.l));
            chk("pcm_right", 32'(right), 32'(e.r));
            hold_l = e.l;
            hold_r = e.r;
            valid_cyc.push_back(cyc);
          end
        end
      end
      if (!valid) begin
        chk("hold_left", 32'(left), 32'(hold_l));
        chk("hold_right", 32'(right), 32'(hold_r));
      end
    end
  end

  task automatic send_bit(input logic l, input logic d);
    bclk = 1'b0; lr = l; sdata = d;
    #(half_ns);
    bclk = 1'b1;
    #(half_ns);
  endtask

  // n bit-clocks of LR=l: the carried LSB of the previous slot, then w[n-1:1].
  task automatic send_slot(input logic l, input logic [31:0] w, input int n);
    send_bit(l, carry);
    for (int i = n - 1; i >= 1; i--) send_bit(l, w[i]);
    carry = w[0];
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, 32'(l), 16);
    send_slot(1'b1, 32'(r), 16);
  endtask

  task automatic push_valid(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back('{is_err: 1'b0, l: l, r: r});
  endtask

  task automatic push_err();
    exp_q.push_back('{is_err: 1'b1, l: 16'h0, r: 16'h0});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_left"}, 32'(left), 32'd0);
    chk({tag, "_right"}, 32'(right), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_err"}, 32'(ferr), 32'd0);
  endtask

  initial begin
    logic [15:0] pl, pr, nl, nr;
    logic [15:0] w;

    repeat (4) @(posedge clk);
    #1 chk_zero("reset");
    #2 rst_n = 1'b1;
    #3;

    // First frame lands in SEEK/partial; second frame completes at next left slot.
    send_frame(16'hA5C3, 16'h1234);
    send_frame(16'hA5C3, 16'h1234);
    push_valid(16'hA5C3, 16'h1234);
    send_frame(16'h8000, 16'h7FFF);
    push_valid(16'h8000, 16'h7FFF);
    send_frame(16'hFFFF, 16'h0001);

    // 15-bit left slot, then a right slot that must be dropped silently.
    push_valid(16'hFFFF, 16'h0001);
    send_slot(1'b0, 32'h0000_1111, 15);
    push_err();
    send_slot(1'b1, 32'h0000_2222, 16);
    send_slot(1'b0, 32'h0000_3333, 16);
    send_slot(1'b1, 32'h0001_2222, 17);
    push_err();
    send_frame(16'h0F0F, 16'hF0F0);

    // Reset in the middle of the right slot.
    push_valid(16'h0F0F, 16'hF0F0);
    send_slot(1'b0, 32'h0000_5555, 16);
    w = 16'hAAAA;
    send_bit(1'b1, carry);
    for (int i = 15; i >= 9; i--) send_bit(1'b1, w[i]);
    rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 8; i >= 1; i--) send_bit(1'b1, w[i]);
    carry = w[0];
    push_err();
    send_frame(16'h6666, 16'h7777);

    // 8x ratio with an arbitrary phase against clk.
    half_ns = 40;
    #($urandom_range(1, 9));
    pl = 16'h6666; pr = 16'h7777;
    for (int f = 0; f < 100; f++) begin
      nl = 16'($urandom);
      nr = 16'($urandom);
      #($urandom_range(0, 9));
      push_valid(pl, pr);
      send_frame(nl, nr);
      pl = nl; pr = nr;
    end
    push_valid(pl, pr);
    send_frame(16'h0000, 16'h0000);

    repeat (20) @(posedge clk);
    chk("expected_queue_drained", 32'(exp_q.size()), 32'd0);
    if (valid_cyc.size() >= 3)
      chk("back_to_back_spacing", valid_cyc[2] - valid_cyc[1], 32'd512);
    else begin
      checks++;
      fails++;
      $display("FAIL back_to_back_spacing: only %0d valid pulses seen, need 3", valid_cyc.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
